dmem_unit: RTL and testbench

- Data-memory stage that sits directly downstream of the pipelined CPU's MEM stage.
- Consumes the CPU's address, store data, write strobe and dm_ctrl; returns load data to the CPU's Data_in the same cycle.
- Contains a word-organised RAM with byte-lane writes, load sign/zero extension, misalignment and range checking, a sticky fault capture register, and load/store event counters.

---
 rtl/dmem_unit.sv | 190 +++++++++++++++++++
 tb/tb_dmem_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_unit.sv
// dmem_unit -- data-memory stage behind the CPU's MEM stage.
//
// Word-organised RAM with byte-lane writes. Loads are combinational and are
// sign/zero-extended. Stores commit on the rising edge. Every access is
// checked for an illegal access type, an out-of-range address and
// misalignment. The first bad access is held in a sticky fault register.
// Separate counters track good loads and good stores.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   mem_r, mem_w       load / store request (store wins when both are high)
//   addr               byte address
//   din                store data (valid bits are the LSBs, per access size)
//   dm_ctrl            access type: word, half, half-u, byte, byte-u
//   dout               load data (combinational, 0 when no good load)
//   fault_clr          clears the sticky fault flag
//   fault_valid, fault_cause, fault_addr, fault_is_store
//                      captured fault (cause 01 misaligned, 10 range, 11 ctrl)
//   load_cnt, store_cnt
//                      good-access event counters, wrapping

module dmem_unit #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mem_r,
  input  logic             mem_w,
  input  logic [31:0]      addr,
  input  logic [31:0]      din,
  input  logic [2:0]       dm_ctrl,
  output logic [31:0]      dout,
  input  logic             fault_clr,
  output logic             fault_valid,
  output logic [1:0]       fault_cause,
  output logic [31:0]      fault_addr,
  output logic             fault_is_store,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_ctrl_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_MISAL = 2'b01,
    CAUSE_RANGE = 2'b10,
    CAUSE_CTRL  = 2'b11
  } cause_e;

  logic [31:0]    mem_q [DEPTH];

  logic [AW-1:0]  widx;
  logic [31:0]    rd_word;
  logic [15:0]    rd_half;
  logic [7:0]     rd_byte;
  logic           is_word, is_half, is_byte;
  logic           illegal, out_of_range, misaligned, bad;
  cause_e         cause;
  logic           access, ld_ok, st_ok;
  logic [3:0]     be;
  logic [31:0]    wdata;

  logic             fault_valid_q, fault_valid_d;
  cause_e           fault_cause_q, fault_cause_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  logic             fault_is_store_q, fault_is_store_d;
  logic [CNT_W-1:0] load_cnt_q, store_cnt_q;

  assign widx    = addr[AW+1:2];
  assign rd_word = mem_q[widx];

  // Access classification and fault priority: ctrl > range > misalignment.
  always_comb begin
    is_word      = (dm_ctrl == DM_WORD);
    is_half      = (dm_ctrl == DM_HALF) || (dm_ctrl == DM_HALF_U);
    is_byte      = (dm_ctrl == DM_BYTE) || (dm_ctrl == DM_BYTE_U);
    illegal      = !(is_word || is_half || is_byte);
    out_of_range = |addr[31:AW+2];
    misaligned   = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    bad          = illegal || out_of_range || misaligned;
    if (illegal)           cause = CAUSE_CTRL;
    else if (out_of_range) cause = CAUSE_RANGE;
    else if (misaligned)   cause = CAUSE_MISAL;
    else                   cause = CAUSE_NONE;
  end

  assign access = mem_r || mem_w;
  assign ld_ok  = mem_r && !mem_w && !bad;
  assign st_ok  = mem_w && !bad;

  // Load path: the pre-edge RAM contents are returned, so a store to the
  // same word becomes visible only from the next cycle.
  always_comb begin
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    dout = '0;
    if (ld_ok) begin
      case (dm_ctrl)
        DM_WORD:   dout = rd_word;
        DM_HALF:   dout = {{16{rd_half[15]}}, rd_half};
        DM_HALF_U: dout = {16'h0000, rd_half};
        DM_BYTE:   dout = {{24{rd_byte[7]}}, rd_byte};
        DM_BYTE_U: dout = {24'h000000, rd_byte};
        default:   dout = '0;
      endcase
    end
  end

  // Store lane enables; data is replicated so every candidate lane holds it.
  always_comb begin
    be    = 4'b0000;
    wdata = din;
    if (is_word) begin
      be = 4'b1111;
    end else if (is_half) begin
      be    = addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{din[15:0]}};
    end else if (is_byte) begin
      be       = 4'b0000;
      be[addr[1:0]] = 1'b1;
      wdata    = {4{din[7:0]}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (st_ok) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // A new fault in the same cycle as fault_clr is captured, not dropped.
  always_comb begin
    fault_valid_d    = fault_valid_q;
    fault_cause_d    = fault_cause_q;
    fault_addr_d     = fault_addr_q;
    fault_is_store_d = fault_is_store_q;
    if (access && bad && (!fault_valid_q || fault_clr)) begin
      fault_valid_d    = 1'b1;
      fault_cause_d    = cause;
      fault_addr_d     = addr;
      fault_is_store_d = mem_w;
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fault_valid_q    <= 1'b0;
      fault_cause_q    <= CAUSE_NONE;
      fault_addr_q     <= '0;
      fault_is_store_q <= 1'b0;
      load_cnt_q       <= '0;
      store_cnt_q      <= '0;
    end else begin
      fault_valid_q    <= fault_valid_d;
      fault_cause_q    <= fault_cause_d;
      fault_addr_q     <= fault_addr_d;
      fault_is_store_q <= fault_is_store_d;
      if (ld_ok) load_cnt_q  <= load_cnt_q + 1'b1;
      if (st_ok) store_cnt_q <= store_cnt_q + 1'b1;
    end
  end

  assign fault_valid    = fault_valid_q;
  assign fault_cause    = fault_cause_q;
  assign fault_addr     = fault_addr_q;
  assign fault_is_store = fault_is_store_q;
  assign load_cnt       = load_cnt_q;
  assign store_cnt      = store_cnt_q;

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit -- directed, self-checking bench for dmem_unit.
// Inputs change on the falling edge. Combinational dout is sampled 1 ns later.
// Registered state is sampled on the next falling edge.

module tb_dmem_unit;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             mem_r, mem_w;
  logic [31:0]      addr, din;
  logic [2:0]       dm_ctrl;
  logic [31:0]      dout;
  logic             fault_clr;
  logic             fault_valid;
  logic [1:0]       fault_cause;
  logic [31:0]      fault_addr;
  logic             fault_is_store;
  logic [CNT_W-1:0] load_cnt, store_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_ld = 0;
  int unsigned exp_st = 0;

  always #5 clk = ~clk;

  dmem_unit #(.DEPTH(128), .AW(7), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .mem_r(mem_r), .mem_w(mem_w), .addr(addr),
    .din(din), .dm_ctrl(dm_ctrl), .dout(dout), .fault_clr(fault_clr),
    .fault_valid(fault_valid), .fault_cause(fault_cause),
    .fault_addr(fault_addr), .fault_is_store(fault_is_store),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] c, input logic clr);
    mem_r = r; mem_w = w; addr = a; din = d; dm_ctrl = c; fault_clr = clr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_ld"}, 32'(load_cnt), 32'(exp_ld));
    check({tag, "_st"}, 32'(store_cnt), 32'(exp_st));
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state
    idle();
    check("rst_dout", dout, 32'h0);
    check("rst_fv", 32'(fault_valid), 32'h0);
    check_cnts("rst");

    // Word store then word load
    drive(1'b0, 1'b1, 32'h10, 32'h89ABCDEF, 3'b000, 1'b0); exp_st++;
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 3'b000, 1'b0); exp_ld++;
    check("ld_w10", dout, 32'h89ABCDEF);
    tick();
    idle();
    check("idle_dout", dout, 32'h0);
    check_cnts("t1");

    // Byte store into lane 3, then extended loads
    drive(1'b0, 1'b1, 32'h13, 32'h000000F0, 3'b011, 1'b0); exp_st++;
    tick();
    drive(1'b1, 1'b0, 32'h13, 32'h0, 3'b011, 1'b0); exp_ld++;
    check("ld_b13", dout, 32'hFFFFFFF0);
    tick();
    drive(1'b1, 1'b0, 32'h13, 32'h0, 3'b100, 1'b0); exp_ld++;
    check("ld_bu13", dout, 32'h000000F0);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 3'b000, 1'b0); exp_ld++;
    check("ld_w10b", dout, 32'hF0ABCDEF);
    tick();

    // Half store into the upper half, then extended loads
    drive(1'b0, 1'b1, 32'h22, 32'h00008001, 3'b001, 1'b0); exp_st++;
    tick();
    drive(1'b1, 1'b0, 32'h22, 32'h0, 3'b001, 1'b0); exp_ld++;
    check("ld_h22", dout, 32'hFFFF8001);
    tick();
    drive(1'b1, 1'b0, 32'h22, 32'h0, 3'b010, 1'b0); exp_ld++;
    check("ld_hu22", dout, 32'h00008001);
    tick();
    drive(1'b1, 1'b0, 32'h20, 32'h0, 3'b000, 1'b0); exp_ld++;
    check("ld_w20", dout, 32'h80010000);
    tick();
    idle();
    check_cnts("t3");

    // Misaligned word store: nothing written, fault captured
    drive(1'b0, 1'b1, 32'h06, 32'hDEADBEEF, 3'b000, 1'b0);
    tick();
    idle();
    check("mis_fv", 32'(fault_valid), 32'h1);
    check("mis_cause", 32'(fault_cause), 32'h1);
    check("mis_addr", fault_addr, 32'h6);
    check("mis_st", 32'(fault_is_store), 32'h1);
    check_cnts("mis");
    drive(1'b1, 1'b0, 32'h04, 32'h0, 3'b000, 1'b0); exp_ld++;
    check("mis_noram", dout, 32'h0);
    tick();

    // Out-of-range half load while a fault is held: ignored, dout 0
    drive(1'b1, 1'b0, 32'h1001, 32'h0, 3'b001, 1'b0);
    check("oor_dout", dout, 32'h0);
    tick();
    idle();
    check("oor_cause", 32'(fault_cause), 32'h1);
    check("oor_addr", fault_addr, 32'h6);
    check_cnts("oor");

    // fault_clr together with an illegal-ctrl load: new fault wins
    drive(1'b1, 1'b0, 32'h40, 32'h0, 3'b101, 1'b1);
    check("ill_dout", dout, 32'h0);
    tick();
    idle();
    check("ill_fv", 32'(fault_valid), 32'h1);
    check("ill_cause", 32'(fault_cause), 32'h3);
    check("ill_addr", fault_addr, 32'h40);
    check("ill_st", 32'(fault_is_store), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    tick();
    idle();
    check("clr_fv", 32'(fault_valid), 32'h0);

    // Store with mem_r also high: store only, new data from the next cycle
    drive(1'b1, 1'b0, 32'h30, 32'h0, 3'b000, 1'b0); exp_ld++;
    check("rdw_pre", dout, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h30, 32'h11111111, 3'b000, 1'b0); exp_st++;
    check("rw_dout", dout, 32'h0);
    tick();
    idle();
    check_cnts("rw");
    drive(1'b1, 1'b0, 32'h30, 32'h0, 3'b000, 1'b0); exp_ld++;
    check("rdw_post", dout, 32'h11111111);
    tick();

    // Load counter wrap
    drive(1'b1, 1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
    repeat (32'hFFFF - exp_ld) tick();
    exp_ld = 32'hFFFF;
    idle();
    check_cnts("pre_wrap");
    drive(1'b1, 1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
    tick();
    exp_ld = 0;
    idle();
    check_cnts("wrap");

    // Plant a fault, then reset in the middle of a store
    drive(1'b0, 1'b1, 32'h31, 32'h0, 3'b000, 1'b0);
    tick();
    idle();
    check("pre_rst_fv", 32'(fault_valid), 32'h1);
    drive(1'b0, 1'b1, 32'h10, 32'h12345678, 3'b000, 1'b0);
    #2 rstn = 1'b0;
    #1;
    exp_ld = 0; exp_st = 0;
    check("arst_fv", 32'(fault_valid), 32'h0);
    check("arst_cause", 32'(fault_cause), 32'h0);
    check("arst_addr", fault_addr, 32'h0);
    check("arst_st", 32'(fault_is_store), 32'h0);
    check_cnts("arst");
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
    check("post_rst_10", dout, 32'h0);
    drive(1'b1, 1'b0, 32'h30, 32'h0, 3'b000, 1'b0);
    check("post_rst_30", dout, 32'h0);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 3'b000, 1'b0);
    check("post_rst_20", dout, 32'h0);
    tick();
    idle();
    exp_ld = 1;
    check_cnts("resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
